noc_tx_arbiter: RTL and testbench

Shares the single outbound NoC port (8-bit address PIO, 32-bit data PIO) between NUM_REQ local requesters on the processor side. Each requester presents a destination and payload with a valid/ready handshake. The arbiter picks one winner round-robin, drives the word onto the PIO lines with a valid strobe in address bit 7, holds it for a fixed window, then inserts a one-cycle gap. It sits between the local compute/IO blocks and the NOC system's addr/data PIO ports.

---
 rtl/noc_arb_pkg.sv | 25 ++
 rtl/noc_rr_pick.sv | 39 +++
 rtl/noc_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_noc_tx_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/noc_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_arb_pkg
// Description : Shared types, field widths and helpers for the NoC TX arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_arb_pkg;

    localparam int NOC_VALID_BIT = 7;
    localparam int NOC_DEST_W    = 7;
    localparam int NOC_DATA_W    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } noc_arb_state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int grant_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : noc_rr_pick
// Description : Combinational round-robin picker; search starts after pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_rr_pick
    import noc_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = grant_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [IDX_W-1:0]   i_pointer,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_grant_any
);

    int w_pos;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_any = 1'b0;
        w_pos       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_pos = int'(i_pointer) + k;
            if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
            if (!o_grant_any && i_req_valid[w_pos]) begin
                o_grant[w_pos] = 1'b1;
                o_grant_idx    = IDX_W'(w_pos);
                o_grant_any    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/noc_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : noc_tx_arbiter
// Description : Round-robin sharing of the outbound NoC addr/data PIO port.
//               Optional NOC_ARB_ACK_EN: ack-driven four-phase HOLD/GAP exit.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_tx_arbiter
    import noc_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*7-1:0]       req_dest,
    input  logic [NUM_REQ*32-1:0]      req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       noc_ack,
    output logic [7:0]                 noc_addr_out,
    output logic [31:0]                noc_data_out,
    output logic                       busy,
    output logic [2:0]                 last_grant
);

    localparam int c_IDX_W = grant_idx_w(NUM_REQ);

    noc_arb_state_e          r_state;
    logic [c_IDX_W-1:0]      r_ptr;
    logic [7:0]              r_addr;
    logic [NOC_DATA_W-1:0]   r_data;
    logic [2:0]              r_last_grant;

    logic [NUM_REQ-1:0]      w_grant;
    logic [c_IDX_W-1:0]      w_idx;
    logic                    w_any;
    logic [NOC_DEST_W-1:0]   w_sel_dest;
    logic [NOC_DATA_W-1:0]   w_sel_data;

    noc_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_pick (
        .i_req_valid (req_valid),
        .i_pointer   (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_idx),
        .o_grant_any (w_any)
    );

    // One-hot AND-OR select of the winner's destination and payload.
    always_comb begin
        w_sel_dest = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_dest = w_sel_dest | req_dest[i*NOC_DEST_W +: NOC_DEST_W];
                w_sel_data = w_sel_data | req_data[i*NOC_DATA_W +: NOC_DATA_W];
            end
        end
    end

`ifdef NOC_ARB_ACK_EN
    logic [1:0] r_ack_sync;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) r_ack_sync <= 2'b00;
        else                r_ack_sync <= {r_ack_sync[0], noc_ack};
    end
`else
    localparam int c_CNT_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_unused_ack;

    assign w_unused_ack = noc_ack;
`endif

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state      <= IDLE;
            r_ptr        <= c_IDX_W'(NUM_REQ - 1);
            r_addr       <= '0;
            r_data       <= '0;
            r_last_grant <= '0;
`ifndef NOC_ARB_ACK_EN
            r_cnt        <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_addr       <= {1'b1, w_sel_dest};
                        r_data       <= w_sel_data;
                        r_last_grant <= 3'(w_idx);
                        r_ptr        <= w_idx;
`ifndef NOC_ARB_ACK_EN
                        r_cnt        <= c_CNT_W'(HOLD_CYCLES - 1);
`endif
                        r_state      <= HOLD;
                    end
                end
                HOLD: begin
`ifdef NOC_ARB_ACK_EN
                    if (r_ack_sync[1]) begin
                        r_addr[NOC_VALID_BIT] <= 1'b0;
                        r_state               <= GAP;
                    end
`else
                    if (r_cnt == '0) begin
                        r_addr[NOC_VALID_BIT] <= 1'b0;
                        r_state               <= GAP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
`endif
                end
                GAP: begin
`ifdef NOC_ARB_ACK_EN
                    if (!r_ack_sync[1]) r_state <= IDLE;
`else
                    r_state <= IDLE;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready    = (r_state == IDLE) ? w_grant : '0;
    assign busy         = (r_state != IDLE);
    assign noc_addr_out = r_addr;
    assign noc_data_out = r_data;
    assign last_grant   = r_last_grant;

endmodule
`default_nettype wire

// File: tb/tb_noc_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_tx_arbiter
// Description : Directed and randomized checks of noc_tx_arbiter against a
//               slot-timing reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_tx_arbiter;

    localparam int N = 4;
    localparam int H = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    v = '0;
    logic [6:0]      dst [N];
    logic [31:0]     dat [N];
    logic [N*7-1:0]  req_dest;
    logic [N*32-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            noc_ack = 1'b0;
    logic [7:0]      noc_addr_out;
    logic [31:0]     noc_data_out;
    logic            busy;
    logic [2:0]      last_grant;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pointer, cycles left in the slot (strobe + gap), last word.
    int          m_ptr, m_busy_left, m_last;
    logic [6:0]  m_dest;
    logic [31:0] m_data;

    int q_gnt[$];
    int q_cyc[$];
    int cyc = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_dest = '0;
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            req_dest[i*7 +: 7]   = dst[i];
            req_data[i*32 +: 32] = dat[i];
        end
    end

    noc_tx_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(H)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .req_valid     (v),
        .req_dest      (req_dest),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .noc_ack       (noc_ack),
        .noc_addr_out  (noc_addr_out),
        .noc_data_out  (noc_data_out),
        .busy          (busy),
        .last_grant    (last_grant)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int gnt_at(input int i);
        return (i < q_gnt.size()) ? q_gnt[i] : -1;
    endfunction

    function automatic int gap_at(input int i);
        return (i + 1 < q_cyc.size()) ? (q_cyc[i+1] - q_cyc[i]) : -1;
    endfunction

    task automatic model_reset();
        m_ptr = N - 1; m_busy_left = 0; m_last = 0; m_dest = '0; m_data = '0;
    endtask

    task automatic new_payload(input int j);
        dst[j] = 7'($urandom);
        dat[j] = $urandom;
    endtask

    // mode 0: winner drops; 1: winner re-requests; 2: fully random traffic
    task automatic run_cycles(input int n, input int mode);
        for (int c = 0; c < n; c++) begin
            int w;
            logic [N-1:0] exp_ready;
            @(negedge clk);
            w = -1;
            if (m_busy_left == 0)
                for (int k = 1; k <= N; k++)
                    if (w < 0 && v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            exp_ready = (w >= 0) ? N'(1 << w) : '0;
            check_eq("req_ready",  req_ready, exp_ready);
            check_eq("busy",       busy, m_busy_left > 0);
            check_eq("addr",       noc_addr_out, {m_busy_left > 1, m_dest});
            check_eq("data",       noc_data_out, m_data);
            check_eq("last_grant", last_grant, m_last);
            for (int j = 0; j < N; j++)
                if (req_ready[j]) begin q_gnt.push_back(j); q_cyc.push_back(cyc); end
            cyc++;
            @(posedge clk);
            if (w >= 0) begin
                m_ptr = w; m_last = w; m_dest = dst[w]; m_data = dat[w];
                m_busy_left = H + 1;
            end else if (m_busy_left > 0) begin
                m_busy_left--;
            end
            #1;
            if (w >= 0) begin
                v[w] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                new_payload(w);
            end
            if (mode == 2)
                for (int j = 0; j < N; j++)
                    if (!v[j] && $urandom_range(0, 2) == 0) begin v[j] = 1'b1; new_payload(j); end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v = '0;
        model_reset();
        q_gnt.delete(); q_cyc.delete();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_addr",  noc_addr_out, 8'h00);
        check_eq("rst_data",  noc_data_out, 32'h0);
        check_eq("rst_ready", req_ready, '0);
        check_eq("rst_busy",  busy, 1'b0);
        check_eq("rst_lg",    last_grant, 3'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int j = 0; j < N; j++) begin dst[j] = '0; dat[j] = '0; end

        // Single requester after reset
        do_reset();
        dst[0] = 7'h05; dat[0] = 32'hDEADBEEF; v = 4'b0001;
        run_cycles(8, 0);
        check_eq("first_gnt", gnt_at(0), 0);

        // Round-robin with everyone valid
        do_reset();
        for (int j = 0; j < N; j++) new_payload(j);
        v = 4'b1111;
        run_cycles(26, 1);
        check_eq("rr0", gnt_at(0), 0);
        check_eq("rr1", gnt_at(1), 1);
        check_eq("rr2", gnt_at(2), 2);
        check_eq("rr3", gnt_at(3), 3);
        check_eq("rr4", gnt_at(4), 0);
        for (int i = 0; i < 4; i++) check_eq("rr_spacing", gap_at(i), H + 2);

        // Fairness: 1 then 3 after last_grant = 1
        do_reset();
        new_payload(1); v = 4'b0010;
        run_cycles(7, 0);
        new_payload(1); new_payload(3); v = 4'b1010;
        run_cycles(14, 0);
        check_eq("fair0", gnt_at(0), 1);
        check_eq("fair1", gnt_at(1), 3);
        check_eq("fair2", gnt_at(2), 1);

        // Arrival during HOLD waits for next IDLE
        do_reset();
        new_payload(0); v = 4'b0001;
        run_cycles(2, 0);
        new_payload(2); v[2] = 1'b1;
        run_cycles(8, 0);
        check_eq("late_gnt", gnt_at(1), 2);
        check_eq("late_spacing", gap_at(0), H + 2);

        // Asynchronous reset in the middle of HOLD
        do_reset();
        dst[0] = 7'h33; dat[0] = 32'hCAFEF00D; v = 4'b0001;
        run_cycles(2, 0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_addr", noc_addr_out, 8'h00);
        check_eq("async_data", noc_data_out, 32'h0);
        check_eq("async_busy", busy, 1'b0);
        model_reset();
        q_gnt.delete(); q_cyc.delete();
        v = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        new_payload(0); new_payload(1); v = 4'b0011;
        run_cycles(8, 0);
        check_eq("post_rst_gnt", gnt_at(0), 0);

        // Random traffic
        do_reset();
        run_cycles(600, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
